// File: rtl/cachepkg.sv
// cachepkg: shared cache types for the cache port arbiter.
// inst_t is the cache operation encoding carried on every request port;
// arb_state_t is the arbiter transaction state.
package cachepkg;

    typedef enum logic [1:0] {
        INST_READ  = 2'd0,
        INST_WRITE = 2'd1,
        INST_FLUSH = 2'd2,
        INST_NOP   = 2'd3
    } inst_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arb_picker.sv
// cache_arb_picker: combinational winner selection for cache_port_arbiter.
// Default: round-robin search starting at rr_ptr_i, wrapping NREQ-1 -> 0.
// With CACHE_ARB_FIXED_PRIO_EN defined: lowest requesting index wins, rr_ptr_i ignored.
module cache_arb_picker
    import cachepkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IW-1:0]   win_idx_o
);

    logic found;

`ifdef CACHE_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^rr_ptr_i;

    // Fixed priority: first requester from index 0 upwards.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found       = 1'b1;
                win_oh_o[i] = 1'b1;
                win_idx_o   = IW'(i);
            end
        end
    end
`else
    // Round-robin: scan indices at/above the pointer first, then wrap to the ones below it.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i >= int'(rr_ptr_i))) begin
                found       = 1'b1;
                win_oh_o[i] = 1'b1;
                win_idx_o   = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i < int'(rr_ptr_i))) begin
                found       = 1'b1;
                win_oh_o[i] = 1'b1;
                win_idx_o   = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one cache slave port among NREQ requester ports.
// One transaction in flight; both sides use the 4-phase request/valid handshake.
// All outputs are registered and clear to 0 on the asynchronous reset.
// Build option: CACHE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// (no round-robin pointer) instead of the default round-robin arbitration.
module cache_port_arbiter
    import cachepkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_request,
    input  inst_t [NREQ-1:0]        req_operation,
    input  logic [NREQ-1:0][AW-1:0] req_addr,
    input  logic [NREQ-1:0][DW-1:0] req_wdata,
    output logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_evict,
    output logic [DW-1:0]           req_rdata,
    output logic                    cache_request,
    output inst_t                   cache_operation,
    output logic [AW-1:0]           cache_addr,
    output logic [DW-1:0]           cache_wdata,
    input  logic                    cache_valid,
    input  logic                    cache_evict,
    input  logic [DW-1:0]           cache_rdata,
    output logic [NREQ-1:0]         grant
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            creq_q, creq_d;
    inst_t           cop_q, cop_d;
    logic [AW-1:0]   caddr_q, caddr_d;
    logic [DW-1:0]   cwdata_q, cwdata_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [NREQ-1:0] revict_q, revict_d;
    logic [DW-1:0]   rrdata_q, rrdata_d;

    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   pick_ptr;

`ifdef CACHE_ARB_FIXED_PRIO_EN
    logic unused_idx;
    assign unused_idx = ^win_idx;
    assign pick_ptr   = '0;
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    assign pick_ptr = rr_ptr_q;
`endif

    cache_arb_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req_i     (req_request),
        .rr_ptr_i  (pick_ptr),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    // Next-state and next-output logic for the IDLE -> ISSUE -> DRAIN handshake.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        creq_d   = creq_q;
        cop_d    = cop_q;
        caddr_d  = caddr_q;
        cwdata_d = cwdata_q;
        rvalid_d = rvalid_q;
        revict_d = revict_q;
        rrdata_d = rrdata_q;
`ifndef CACHE_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                // A lingering cache_valid (e.g. after a mid-transaction reset) blocks issue.
                if (|req_request && !cache_valid) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (win_oh[i]) begin
                            cop_d    = req_operation[i];
                            caddr_d  = req_addr[i];
                            cwdata_d = req_wdata[i];
                        end
                    end
                    creq_d  = 1'b1;
                    grant_d = win_oh;
`ifndef CACHE_ARB_FIXED_PRIO_EN
                    gidx_d  = win_idx;
`endif
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (cache_valid) begin
                    rrdata_d = cache_rdata;
                    revict_d = cache_evict ? grant_q : '0;
                    rvalid_d = grant_q;
                    creq_d   = 1'b0;
                    state_d  = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // Both sides must have released; order between them does not matter.
                if (!cache_valid && !(|(req_request & grant_q))) begin
                    rvalid_d = '0;
                    revict_d = '0;
                    grant_d  = '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
`endif
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers; every output clears on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            creq_q   <= 1'b0;
            cop_q    <= INST_READ;
            caddr_q  <= '0;
            cwdata_q <= '0;
            rvalid_q <= '0;
            revict_q <= '0;
            rrdata_q <= '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
            gidx_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            creq_q   <= creq_d;
            cop_q    <= cop_d;
            caddr_q  <= caddr_d;
            cwdata_q <= cwdata_d;
            rvalid_q <= rvalid_d;
            revict_q <= revict_d;
            rrdata_q <= rrdata_d;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
`endif
        end
    end

    assign grant           = grant_q;
    assign cache_request   = creq_q;
    assign cache_operation = cop_q;
    assign cache_addr      = caddr_q;
    assign cache_wdata     = cwdata_q;
    assign req_valid       = rvalid_q;
    assign req_evict       = revict_q;
    assign req_rdata       = rrdata_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: table-driven transactions with a response scoreboard,
// plus hand-written sequences for reset mid-transaction and protocol violation.
module tb_cache_port_arbiter;
    import cachepkg::*;

    logic             clock;
    logic             reset;
    logic [1:0]       req_request;
    inst_t [1:0]      req_operation;
    logic [1:0][31:0] req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0]       req_valid;
    logic [1:0]       req_evict;
    logic [7:0]       req_rdata;
    logic             cache_request;
    inst_t            cache_operation;
    logic [31:0]      cache_addr;
    logic [7:0]       cache_wdata;
    logic             cache_valid;
    logic             cache_evict;
    logic [7:0]       cache_rdata;
    logic [1:0]       grant;

    cache_port_arbiter #(
        .NREQ (2),
        .AW   (32),
        .DW   (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_request     (req_request),
        .req_operation   (req_operation),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_valid       (req_valid),
        .req_evict       (req_evict),
        .req_rdata       (req_rdata),
        .cache_request   (cache_request),
        .cache_operation (cache_operation),
        .cache_addr      (cache_addr),
        .cache_wdata     (cache_wdata),
        .cache_valid     (cache_valid),
        .cache_evict     (cache_evict),
        .cache_rdata     (cache_rdata),
        .grant           (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // order: 0 = release both together, 1 = requester first, 2 = cache_valid first
    typedef struct {
        logic [1:0]  mask;
        inst_t       op0;
        inst_t       op1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [7:0]  wd0;
        logic [7:0]  wd1;
        logic [7:0]  rdata;
        logic        evict;
        int          lat;
        int          order;
        int          w_rr;
        int          w_fx;
    } vec_t;

    typedef struct {
        int         w;
        logic [7:0] rdata;
        logic       evict;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int pick_w(input vec_t v);
`ifdef CACHE_ARB_FIXED_PRIO_EN
        return v.w_fx;
`else
        return v.w_rr;
`endif
    endfunction

    task automatic start_txn(input vec_t v, input int w);
        int   n;
        exp_t e;
        req_operation[0] = v.op0;
        req_operation[1] = v.op1;
        req_addr[0]      = v.addr0;
        req_addr[1]      = v.addr1;
        req_wdata[0]     = v.wd0;
        req_wdata[1]     = v.wd1;
        req_request      = v.mask;
        e.w = w; e.rdata = v.rdata; e.evict = v.evict;
        sb.push_back(e);
        n = 0;
        do begin tick(); n++; end while (!cache_request && n < 20);
        check("issue_latency", n, 1);
        check("grant", grant, oh(w));
        check("cache_addr", cache_addr, (w == 1) ? v.addr1 : v.addr0);
        check("cache_op", cache_operation, (w == 1) ? v.op1 : v.op0);
        check("cache_wdata", cache_wdata, (w == 1) ? v.wd1 : v.wd0);
    endtask

    task automatic finish_txn(input vec_t v);
        int         n;
        exp_t       e;
        logic [1:0] m;
        for (int i = 0; i < v.lat; i++) tick();
        check("hold_issue", {cache_request, req_valid}, 3'b100);
        cache_rdata = v.rdata;
        cache_evict = v.evict;
        cache_valid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (req_valid == 2'b00 && n < 20);
        check("valid_latency", n, 1);
        check("sb_empty", (sb.size() == 0), 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            m = oh(e.w);
            cache_rdata = ~v.rdata;
            cache_evict = 1'b0;
            check("req_valid", req_valid, m);
            check("req_rdata", req_rdata, e.rdata);
            check("req_evict", req_evict, e.evict ? m : 2'b00);
            check("cache_req_drop", cache_request, 0);
            case (v.order)
                1: begin
                    req_request = req_request & ~m;
                    tick();
                    check("drain_wait_cv", {grant, req_valid}, {m, m});
                    check("rdata_stable", req_rdata, e.rdata);
                    cache_valid = 1'b0;
                end
                2: begin
                    cache_valid = 1'b0;
                    tick();
                    check("drain_wait_req", {grant, req_valid}, {m, m});
                    check("rdata_stable", req_rdata, e.rdata);
                    req_request = req_request & ~m;
                end
                default: begin
                    cache_valid = 1'b0;
                    req_request = req_request & ~m;
                end
            endcase
            tick();
            check("drain_exit", {grant, req_valid, req_evict}, 6'b0);
        end
        cache_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v6a, v6b, vrst, vf;
        exp_t e;
        vecs[0] = '{2'b11, INST_READ,  INST_WRITE, 32'h2000, 32'h3000, 8'h11, 8'h22, 8'h5A, 1'b0, 1, 0, 0, 0};
        vecs[1] = '{2'b11, INST_WRITE, INST_READ,  32'h2004, 32'h3004, 8'h33, 8'h44, 8'h6B, 1'b0, 2, 0, 1, 0};
        vecs[2] = '{2'b11, INST_READ,  INST_READ,  32'h2008, 32'h3008, 8'h55, 8'h66, 8'h7C, 1'b0, 0, 0, 0, 0};
        vecs[3] = '{2'b11, INST_FLUSH, INST_WRITE, 32'h200C, 32'h300C, 8'h77, 8'h88, 8'h8D, 1'b0, 1, 0, 1, 0};
        vecs[4] = '{2'b01, INST_READ,  INST_READ,  32'h1000, 32'h0000, 8'h00, 8'h00, 8'hA5, 1'b0, 3, 2, 0, 0};
        vecs[5] = '{2'b10, INST_READ,  INST_WRITE, 32'h0000, 32'h1010, 8'h00, 8'hC3, 8'h1E, 1'b1, 2, 1, 1, 1};
        vecs[6] = '{2'b11, INST_READ,  INST_READ,  32'h6000, 32'h7000, 8'h01, 8'h02, 8'h2F, 1'b1, 1, 0, 0, 0};
        vecs[7] = '{2'b11, INST_WRITE, INST_READ,  32'h6004, 32'h7004, 8'h03, 8'h04, 8'h40, 1'b0, 0, 2, 1, 0};
        v6a  = '{2'b01, INST_READ, INST_READ,  32'h4000, 32'h4100, 8'h00, 8'h00, 8'h3C, 1'b0, 1, 0, 0, 0};
        v6b  = '{2'b11, INST_READ, INST_WRITE, 32'h4004, 32'h4104, 8'h09, 8'h0A, 8'h4B, 1'b0, 1, 0, 1, 0};
        vrst = '{2'b10, INST_READ, INST_WRITE, 32'h5000, 32'h5100, 8'h00, 8'h77, 8'h99, 1'b0, 2, 0, 1, 1};
        vf   = '{2'b11, INST_NOP,  INST_READ,  32'h8000, 32'h9000, 8'h0B, 8'h0C, 8'hD2, 1'b0, 1, 0, 0, 0};

        reset       = 1'b1;
        req_request = 2'b00;
        req_operation[0] = INST_READ;
        req_operation[1] = INST_READ;
        req_addr    = '0;
        req_wdata   = '0;
        cache_valid = 1'b0;
        cache_evict = 1'b0;
        cache_rdata = 8'h00;
        tick();
        tick();
        check("rst_ctrl", {cache_request, grant, req_valid, req_evict, req_rdata}, 0);
        check("rst_cache_addr", cache_addr, 0);
        check("rst_cache_op_wd", {cache_operation, cache_wdata}, 0);
        reset = 1'b0;
        tick();

        // Table: round-robin/fixed grant sequence, single read, evict, release orders.
        for (int i = 0; i < 8; i++) begin
            start_txn(vecs[i], pick_w(vecs[i]));
            finish_txn(vecs[i]);
        end

        // Requester drops its request during ISSUE: single-cycle req_valid pulse.
        start_txn(v6a, 0);
        req_request = 2'b00;
        tick();
        check("viol_issue_hold", cache_request, 1);
        cache_rdata = v6a.rdata;
        cache_valid = 1'b1;
        tick();
        check("viol_sb", (sb.size() == 0), 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("viol_valid", req_valid, oh(e.w));
            check("viol_rdata", req_rdata, e.rdata);
        end
        cache_valid = 1'b0;
        tick();
        check("viol_pulse_end", {req_valid, grant}, 4'b0);
        start_txn(v6b, pick_w(v6b));
        finish_txn(v6b);

        // Reset in ISSUE while cache_valid is high; req 1 pending.
        req_request = 2'b01;
        req_addr[0] = 32'h5000;
        req_operation[0] = INST_READ;
        tick();
        check("rst5_issue", {cache_request, grant}, 3'b101);
        cache_valid = 1'b1;
        cache_rdata = 8'hEE;
        req_request = 2'b11;
        req_addr[1] = vrst.addr1;
        req_operation[1] = vrst.op1;
        req_wdata[1] = vrst.wd1;
        #1 reset = 1'b1;
        #1;
        check("rst5_outputs", {cache_request, grant, req_valid, req_evict, req_rdata}, 0);
        check("rst5_cache_addr", cache_addr, 0);
        #1 reset = 1'b0;
        req_request = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst5_blocked", {cache_request, grant}, 3'b000);
        end
        cache_valid = 1'b0;
        e.w = 1; e.rdata = vrst.rdata; e.evict = vrst.evict;
        sb.push_back(e);
        tick();
        check("rst5_reissue", {cache_request, grant}, 3'b110);
        check("rst5_addr", cache_addr, vrst.addr1);
        check("rst5_op_wd", {cache_operation, cache_wdata}, {vrst.op1, vrst.wd1});
        finish_txn(vrst);

        start_txn(vf, pick_w(vf));
        finish_txn(vf);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
